mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between the instruction-fetch side (PC-addressed fetch) and the data side (load/store stage).
- Sequences each access with a req/ack handshake to memory and a ready pulse back to the winner.
- The loser stalls until its own ready pulse.
- A watchdog aborts hung memory transactions and flags an error.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_watchdog.sv | 30 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Optional build macro (consumed by mem_port_arbiter): MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

   localparam int ADDR_W_DEF      = 16;
   localparam int DATA_W_DEF      = 32;
   localparam int TIMEOUT_CYC_DEF = 64;

   // Read data returned to the requester when a transaction is aborted
   localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog: counts cycles while enabled and flags the last
// allowed cycle so the arbiter can abort a hung memory access.
module mem_arb_watchdog #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   // 16 bits covers the whole legal TIMEOUT_CYC range (2..65535)
   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

   logic [15:0] cnt;

   // Cycle counter: clear has priority, otherwise count while enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 16'd1;
   end

   assign expire = en && (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the
// instruction-fetch port (I) and the load/store port (D).
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN -- alternate grants on
// contention instead of fixed D-over-I priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              err
);

   state_t state;
   gnt_t   gnt;
   gnt_t   pick;
   logic   expire;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   gnt_t   last_gnt;
`endif

   // Only WAIT cycles are counted; any other state rearms the watchdog
   mem_arb_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (state != WAIT),
      .en     (state == WAIT),
      .expire (expire)
   );

   // Grant selection for the current IDLE cycle; a lone requester always wins
   always_comb begin
      pick = GNT_I;
      if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         pick = (last_gnt == GNT_D) ? GNT_I : GNT_D;
`else
         pick = GNT_D;
`endif
      end else if (d_req) begin
         pick = GNT_D;
      end
   end

   // Arbitration FSM with registered memory-side and requester-side outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= GNT_I;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_ready   <= 1'b0;
         d_ready   <= 1'b0;
         err       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_gnt  <= GNT_I;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  gnt     <= pick;
                  mem_req <= 1'b1;
                  state   <= WAIT;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_gnt <= pick;
`endif
                  if (pick == GNT_D) begin
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     // fetches never write, whatever the data side drives
                     mem_we    <= 1'b0;
                     mem_addr  <= i_addr;
                     mem_wdata <= '0;
                  end
               end
            end
            WAIT: begin
               // an ack arriving on the expiry cycle still wins
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= RESP;
                  if (gnt == GNT_D) begin
                     d_rdata <= mem_rdata;
                     d_ready <= 1'b1;
                  end else begin
                     i_rdata <= mem_rdata;
                     i_ready <= 1'b1;
                  end
               end else if (expire) begin
                  mem_req <= 1'b0;
                  err     <= 1'b1;
                  state   <= RESP;
                  if (gnt == GNT_D) begin
                     d_rdata <= DATA_W'(TIMEOUT_RDATA);
                     d_ready <= 1'b1;
                  end else begin
                     i_rdata <= DATA_W'(TIMEOUT_RDATA);
                     i_ready <= 1'b1;
                  end
               end
            end
            RESP: begin
               i_ready <= 1'b0;
               d_ready <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               i_ready <= 1'b0;
               d_ready <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand
// sequences for reset/contention/back-to-back, and a randomized phase
// checked against a transaction-level timing model.
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, d_req, d_we, mem_ack;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wdata, mem_rdata;
   logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
   logic          i_ready, d_ready, mem_req, mem_we, err;
   logic [AW-1:0] mem_addr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_ready   (i_ready),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .err       (err)
   );

   typedef struct {
      bit          use_d;
      bit          we;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          lat;       // WAIT cycle index carrying mem_ack; >= TO means never
      logic [31:0] rdata;
      logic [15:0] exp_addr;
      bit          exp_we;
      int          exp_wait;  // number of cycles mem_req is high
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      if (v.use_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
         if (!d_req) d_we = v.we;
      end
   endtask

   // Called at the negedge where the request was just driven (arbiter idle)
   task automatic serve(input vec_t v, input bit drop);
      int n;
      @(negedge clk);
      chk("mem_req_rise", mem_req, 1);
      chk("mem_addr", mem_addr, v.exp_addr);
      if (v.exp_we) chk("mem_wdata", mem_wdata, v.wdata);
      n = 0;
      while (mem_req === 1'b1 && n < 100) begin
         chk("mem_we", mem_we, v.exp_we);
         mem_ack   = (n == v.lat);
         mem_rdata = v.rdata;
         n++;
         @(negedge clk);
      end
      mem_ack = 1'b0;
      chk("wait_cycles", n, v.exp_wait);
      chk("ready_winner", v.use_d ? d_ready : i_ready, 1);
      chk("ready_loser", v.use_d ? i_ready : d_ready, 0);
      chk("rdata", v.use_d ? d_rdata : i_rdata, v.exp_rdata);
      if (drop) begin
         if (v.use_d) d_req = 1'b0; else i_req = 1'b0;
      end
      @(negedge clk);
      chk("ready_one_cycle", {i_ready, d_ready}, 0);
      chk("idle_mem_req", mem_req, 0);
      chk("err", err, v.exp_err);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      vec_t vd, vi;
      // transaction-level model state for the random phase
      bit          busy, t_win, t_to, t_we, i_pend, d_pend, dwe, last_m, err_m, in_wait;
      int          t_start, t_r;
      logic [15:0] t_addr, ia, da;
      logic [31:0] t_wdata, t_rdata, dwd, i_rd_m, d_rd_m;

      vecs[0] = '{0, 1, 16'h0004, 32'h0,        3,   32'h08000010, 16'h0004, 0, 4, 32'h08000010, 0};
      vecs[1] = '{1, 1, 16'h0020, 32'hCAFEF00D, 0,   32'h11111111, 16'h0020, 1, 1, 32'h11111111, 0};
      vecs[2] = '{1, 0, 16'h0100, 32'h0,        7,   32'hA5A5A5A5, 16'h0100, 0, 8, 32'hA5A5A5A5, 0};
      vecs[3] = '{1, 0, 16'h0044, 32'h0,        255, 32'hDEADBEEF, 16'h0044, 0, 8, 32'h0,        1};
      vecs[4] = '{0, 0, 16'h0008, 32'h0,        1,   32'h12345678, 16'h0008, 0, 2, 32'h12345678, 1};
      vecs[5] = '{0, 1, 16'hFFFF, 32'h0,        0,   32'hFFFFFFFF, 16'hFFFF, 0, 1, 32'hFFFFFFFF, 1};

      // ---- reset with a fetch pending
      rst = 1'b1; i_req = 1'b1; i_addr = 16'h0004;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_ready", {i_ready, d_ready}, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      #1 chk("release_mem_req", mem_req, 0);
      @(negedge clk);
      chk("first_mem_req", mem_req, 1);
      chk("first_mem_addr", mem_addr, 16'h0004);
      mem_ack = 1'b1; mem_rdata = 32'h0BADBEEF;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("first_i_ready", i_ready, 1);
      chk("first_i_rdata", i_rdata, 32'h0BADBEEF);
      i_req = 1'b0;
      @(negedge clk);
      chk("first_i_ready_drop", i_ready, 0);

      // ---- directed single-port vectors (includes ack-on-expiry and timeout)
      for (int k = 0; k < 6; k++) begin
         drive(vecs[k]);
         serve(vecs[k], 1'b1);
      end

      // ---- contention: D store and I fetch rise together
      vd = '{1, 1, 16'h0020, 32'hCAFEF00D, 0, 32'h0,        16'h0020, 1, 1, 32'h0,        1};
      vi = '{0, 0, 16'h0010, 32'h0,        2, 32'h55AA55AA, 16'h0010, 0, 3, 32'h55AA55AA, 1};
      drive(vd);
      drive(vi);
      serve(vd, 1'b1);
      serve(vi, 1'b1);

      // ---- back-to-back loads with d_req held across ready
      vd = '{1, 0, 16'h0300, 32'h0, 2, 32'h00000001, 16'h0300, 0, 3, 32'h00000001, 1};
      vi = '{1, 0, 16'h0300, 32'h0, 0, 32'h00000002, 16'h0300, 0, 1, 32'h00000002, 1};
      drive(vd);
      serve(vd, 1'b0);
      serve(vi, 1'b1);

      // ---- reset during WAIT, then a stray ack
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
      @(negedge clk);
      chk("midwait_mem_req", mem_req, 1);
      rst = 1'b1; d_req = 1'b0;
      #1;
      chk("midrst_mem_req", mem_req, 0);
      chk("midrst_err", err, 0);
      chk("midrst_d_ready", d_ready, 0);
      @(negedge clk);
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("stray_mem_req", mem_req, 0);
      chk("stray_ready", {i_ready, d_ready}, 0);
      chk("stray_d_rdata", d_rdata, 0);
      @(negedge clk);
      chk("stray_mem_req2", mem_req, 0);
      chk("stray_ready2", {i_ready, d_ready}, 0);

      // ---- randomized traffic against a transaction-timing model
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      busy = 0; err_m = 0; i_rd_m = '0; d_rd_m = '0; last_m = 0;
      i_pend = 0; d_pend = 0; t_start = 0; t_r = 0; t_win = 0; t_to = 0;
      t_we = 0; t_addr = '0; t_wdata = '0; t_rdata = '0;
      ia = '0; da = '0; dwe = 0; dwd = '0;
      for (int c = 0; c < 3000; c++) begin
         if (busy && c == t_r + 2) busy = 0;
         if (busy && c == t_r + 1) begin
            if (t_to) err_m = 1;
            if (t_win) d_rd_m = t_to ? 32'h0 : t_rdata;
            else       i_rd_m = t_to ? 32'h0 : t_rdata;
         end
         in_wait = busy && c > t_start && c <= t_r;
         chk("rnd_mem_req", mem_req, in_wait);
         if (in_wait) begin
            chk("rnd_mem_addr", mem_addr, t_addr);
            chk("rnd_mem_we", mem_we, t_we);
            if (t_we) chk("rnd_mem_wdata", mem_wdata, t_wdata);
         end
         chk("rnd_i_ready", i_ready, busy && c == t_r + 1 && !t_win);
         chk("rnd_d_ready", d_ready, busy && c == t_r + 1 && t_win);
         chk("rnd_i_rdata", i_rdata, i_rd_m);
         chk("rnd_d_rdata", d_rdata, d_rd_m);
         chk("rnd_err", err, err_m);

         // requesters react to their ready pulse in the following cycle
         if (busy && c == t_r + 1) begin
            if (t_win) d_pend = 0; else i_pend = 0;
         end
         if (!i_pend && $urandom_range(0, 2) == 0) begin
            i_pend = 1; ia = 16'($urandom);
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1; da = 16'($urandom); dwe = 1'($urandom); dwd = $urandom;
         end

         // arbiter free: pick a winner and plan the whole transaction
         if (!busy && (i_pend || d_pend)) begin
            if (i_pend && d_pend) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
               t_win = !last_m;
`else
               t_win = 1;
`endif
            end else begin
               t_win = d_pend;
            end
            last_m  = t_win;
            busy    = 1;
            t_start = c;
            t_addr  = t_win ? da : ia;
            t_we    = t_win ? dwe : 1'b0;
            t_wdata = dwd;
            t_rdata = $urandom;
            t_to    = ($urandom_range(0, 15) == 0);
            t_r     = t_to ? c + TO : c + 1 + int'($urandom_range(0, TO - 1));
         end

         in_wait   = busy && c > t_start && c <= t_r;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (in_wait && !t_to && c == t_r) begin
            mem_ack = 1'b1; mem_rdata = t_rdata;
         end else if (!in_wait && $urandom_range(0, 7) == 0) begin
            mem_ack = 1'b1;
         end
         i_req   = i_pend;
         i_addr  = i_pend ? ia : 16'($urandom);
         d_req   = d_pend;
         d_addr  = d_pend ? da : 16'($urandom);
         d_we    = d_pend ? dwe : 1'($urandom);
         d_wdata = d_pend ? dwd : $urandom;
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
